// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and width helpers.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Index width that is never zero, so a 1-bit index survives degenerate sizes.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between N_REQ producers, the write arbiter and the fifo_sync write port.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = idx_w(N_REQ);

  // A beat moves from requester i on a clock edge where req_valid[i] & req_ready[i];
  // req_ready is combinational and at most one bit is set, which is exactly fifo_wr_en.
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        pause;
  logic                        fifo_full;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_din;
  logic [IW-1:0]               last_grant;
  arb_state_e                  dbg_state;

  modport master (
    output req_valid, req_data, pause, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, last_grant, dbg_state
  );

  modport slave (
    input  req_valid, req_data, pause, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, last_grant, dbg_state
  );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin pick: rotate requests by the pointer, find the first set bit, rotate back.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_req[IW'((int'(i_ptr) + k) % N)];
    end
    o_any   = |w_rot;
    o_idx   = '0;
    o_grant = '0;
    // Descending scan so the lowest rotated position is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end
    if (o_any) o_grant = N'(1) << o_idx;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_sync write port among N_REQ producers.
// Define FIFO_ARB_BURST_EN to let a granted requester keep the port for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_wr_arbiter: N_REQ must be 2..8 and MAX_BURST at least 1");
  end

  arb_state_e          r_state, w_state_nxt;
  logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]       r_last_grant, w_last_grant_nxt;
  logic [N_REQ-1:0]    w_elig;
  logic [N_REQ-1:0]    w_pick_grant;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic [N_REQ-1:0]    w_grant;
  logic [DATA_WIDTH-1:0] w_din;

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = clog2(MAX_BURST + 1);
  logic [IW-1:0] r_lock_id, w_lock_id_nxt;
  logic [BW-1:0] r_burst_cnt, w_burst_cnt_nxt;
`endif

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(N_REQ - 1)) return '0;
    return v + IW'(1);
  endfunction

  // rst is part of eligibility so grants drop in the same cycle reset rises.
  assign w_elig = bus.req_valid & {N_REQ{~bus.fifo_full & ~bus.pause & ~rst}};

  rr_priority_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_grant          = '0;
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_last_grant_nxt = r_last_grant;
`ifdef FIFO_ARB_BURST_EN
    w_lock_id_nxt    = r_lock_id;
    w_burst_cnt_nxt  = r_burst_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant          = w_pick_grant;
          w_rr_ptr_nxt     = wrap_inc(w_pick_idx);
          w_last_grant_nxt = w_pick_idx;
`ifdef FIFO_ARB_BURST_EN
          if (MAX_BURST > 1) begin
            w_state_nxt     = ST_LOCK;
            w_lock_id_nxt   = w_pick_idx;
            w_burst_cnt_nxt = BW'(1);
          end
`endif
        end
      end
`ifdef FIFO_ARB_BURST_EN
      ST_LOCK: begin
        // A withdrawn holder releases the lock without a beat; full/pause merely stall.
        if (!bus.req_valid[r_lock_id]) begin
          w_state_nxt     = ST_IDLE;
          w_rr_ptr_nxt    = wrap_inc(r_lock_id);
          w_burst_cnt_nxt = '0;
        end else if (w_elig[r_lock_id]) begin
          w_grant[r_lock_id] = 1'b1;
          w_last_grant_nxt   = r_lock_id;
          if (r_burst_cnt == BW'(MAX_BURST - 1)) begin
            w_state_nxt     = ST_IDLE;
            w_rr_ptr_nxt    = wrap_inc(r_lock_id);
            w_burst_cnt_nxt = '0;
          end else begin
            w_burst_cnt_nxt = r_burst_cnt + BW'(1);
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_din = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_last_grant <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_id   <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_lock_id   <= w_lock_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end
`endif

  assign bus.req_ready  = w_grant;
  assign bus.fifo_wr_en = |w_grant;
  assign bus.fifo_din   = w_din;
  assign bus.last_grant = r_last_grant;
  assign bus.dbg_state  = r_state;

endmodule
